// File: rtl/tiger_icache_pkg.sv
// -----------------------------------------------------------------------------
// tiger_icache_pkg
// Shared definitions for the instruction-cache line-fill engine:
//   - default geometry (word width, words per line, word-select bits, address
//     width) and the derived byte-in-word offset width
//   - the fill state machine encoding
// -----------------------------------------------------------------------------
package tiger_icache_pkg;

    localparam int N_DEF = 32;                 // word width in bits
    localparam int M_DEF = 8;                  // words per cache line
    localparam int S_DEF = 3;                  // log2(M_DEF)
    localparam int A_DEF = 32;                 // byte-address width
    localparam int OB    = $clog2(N_DEF / 8);  // byte-in-word bits for the default word width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    // Byte-in-word offset width for an arbitrary word width.
    function automatic int ob_bits(input int n);
        return $clog2(n / 8);
    endfunction

endpackage

// File: rtl/tiger_icache_line_fill.sv
// -----------------------------------------------------------------------------
// tiger_icache_line_fill
// Fetches one instruction-cache line over an Avalon-MM burst read after a miss.
// The line is requested from its aligned base address, the beats are stored in
// order, the missed (critical) word is forwarded as soon as it arrives, and a
// one-cycle pulse announces the completed line.
//
// Ports
//   clk                in   sole clock, rising edge
//   reset              in   synchronous, active-high
//   miss_req           in   line fill request (only honoured while idle)
//   miss_addr          in   byte address of the missing instruction
//   busy               out  fill in progress
//   avm_address        out  line-aligned burst start address
//   avm_read           out  burst read command
//   avm_burstcount     out  burst length, always M
//   avm_waitrequest    in   command stall from the slave
//   avm_readdata       in   returned beat
//   avm_readdatavalid  in   beat qualifier
//   line_data          out  assembled line, word i at [i*N +: N]
//   line_valid         out  one-cycle pulse, line_data complete
//   fwd_valid          out  one-cycle pulse, critical word available
//   fwd_data           out  critical word
// -----------------------------------------------------------------------------
module tiger_icache_line_fill
    import tiger_icache_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int S = S_DEF,
    parameter int A = A_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_req,
    input  logic [A-1:0]     miss_addr,
    output logic             busy,
    output logic [A-1:0]     avm_address,
    output logic             avm_read,
    output logic [S:0]       avm_burstcount,
    input  logic             avm_waitrequest,
    input  logic [N-1:0]     avm_readdata,
    input  logic             avm_readdatavalid,
    output logic [M*N-1:0]   line_data,
    output logic             line_valid,
    output logic             fwd_valid,
    output logic [N-1:0]     fwd_data
);

    localparam int OBL = ob_bits(N);              // byte-in-word bits
    localparam int LB  = S + OBL;                 // bits cleared to line-align
    localparam logic [S:0] LAST_BEAT = (S+1)'(M - 1);

    fill_state_t        r_state;
    fill_state_t        w_state_next;
    logic [A-1:0]       r_base;
    logic [S-1:0]       r_crit;
    logic [S:0]         r_cnt;
    logic [N-1:0]       r_words [M];
    logic [N-1:0]       r_fwd_data;
    logic               r_fwd_valid;

    logic               w_accept;
    logic               w_beat;
    logic               w_crit_hit;
    logic [A-1:0]       w_base;
    logic [S-1:0]       w_crit;
    logic [M-1:0]       w_word_we;

    // Line-aligned base and critical word index of the incoming miss.
    assign w_base = {miss_addr[A-1:LB], {LB{1'b0}}};
    assign w_crit = miss_addr[LB-1:OBL];

    // Byte offset within a word never matters for a word-granular fill.
    generate
        if (OBL > 0) begin : g_unused_offset
            logic w_unused_offset;
            assign w_unused_offset = ^miss_addr[OBL-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                // Beats are only meaningful here; strays in other states fall through.
                if (avm_readdatavalid) begin
                    w_beat = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_crit_hit = w_beat && (r_cnt == {1'b0, r_crit});

    // One write enable per word slot of the line register.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_word
            assign w_word_we[gi]           = w_beat && (r_cnt == (S+1)'(gi));
            assign line_data[gi*N +: N]    = r_words[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State, address, counter and forwarding registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_crit      <= '0;
            r_cnt       <= '0;
            r_fwd_data  <= '0;
            r_fwd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fwd_valid <= 1'b0;
            if (w_accept) begin
                r_base <= w_base;
                r_crit <= w_crit;
                r_cnt  <= '0;
            end
            if (w_beat) begin
                r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + (S+1)'(1);
            end
            // Registered forward: the pulse appears in the cycle after the beat.
            if (w_crit_hit) begin
                r_fwd_data  <= avm_readdata;
                r_fwd_valid <= 1'b1;
            end
        end
    end

    // Line register: words persist until overwritten by the next fill's beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                if (w_word_we[i]) begin
                    r_words[i] <= avm_readdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy           = (r_state != ST_IDLE);
    assign avm_read       = (r_state == ST_REQ);
    assign avm_address    = r_base;
    assign avm_burstcount = (S+1)'(M);
    assign line_valid     = (r_state == ST_DONE);
    assign fwd_valid      = r_fwd_valid;
    assign fwd_data       = r_fwd_data;

endmodule

// File: tb/tb_tiger_icache_line_fill.sv
module tb_tiger_icache_line_fill;

    logic           clk = 1'b0;
    logic           reset;
    logic           miss_req;
    logic [31:0]    miss_addr;
    logic           busy;
    logic [31:0]    avm_address;
    logic           avm_read;
    logic [3:0]     avm_burstcount;
    logic           avm_waitrequest;
    logic [31:0]    avm_readdata;
    logic           avm_readdatavalid;
    logic [255:0]   line_data;
    logic           line_valid;
    logic           fwd_valid;
    logic [31:0]    fwd_data;

    tiger_icache_line_fill dut (
        .clk               (clk),
        .reset             (reset),
        .miss_req          (miss_req),
        .miss_addr         (miss_addr),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .line_data         (line_data),
        .line_valid        (line_valid),
        .fwd_valid         (fwd_valid),
        .fwd_data          (fwd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [31:0]  exp_addr     [$];
    logic [31:0]  exp_fwd      [$];
    int           exp_fwd_cyc  [$];
    logic [255:0] exp_line     [$];
    int           exp_line_cyc [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = '0;
    int          n_fwd_seen  = 0;
    int          n_line_seen = 0;

    always @(negedge clk) begin
        logic [31:0] a;
        int          c;
        if (stall_prev && !reset) begin
            check("cmd_hold_read", avm_read, 1'b1);
            check("cmd_hold_addr", avm_address, stall_addr);
        end
        stall_prev = avm_read && avm_waitrequest && !reset;
        stall_addr = avm_address;

        if (avm_read && !avm_waitrequest) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_cmd", 1'b1, 1'b0);
            end else begin
                a = exp_addr.pop_front();
                check("cmd_addr", avm_address, a);
                check("burstcount", avm_burstcount, 4'd8);
            end
        end

        if (fwd_valid) begin
            if (exp_fwd.size() == 0 || exp_fwd_cyc.size() == 0) begin
                check("unexpected_fwd", 1'b1, 1'b0);
            end else begin
                a = exp_fwd.pop_front();
                c = exp_fwd_cyc.pop_front();
                check("fwd_data", fwd_data, a);
                check("fwd_cycle", cyc, c);
            end
            n_fwd_seen++;
        end

        if (line_valid) begin
            n_line_seen++;
            if (exp_line.size() == 0 || exp_line_cyc.size() == 0) begin
                check("unexpected_line", 1'b1, 1'b0);
            end else begin
                check("line_data", line_data, exp_line.pop_front());
                c = exp_line_cyc.pop_front();
                check("line_cycle", cyc, c);
                check("fwd_not_after_line", n_fwd_seen, n_line_seen);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus: one complete (or aborted) line fill with a reference model
    // ------------------------------------------------------------------------
    task automatic do_fill(input logic [31:0] addr, input int nwait, input int gap_max,
                           input bit spam, input int abort_after, input bit directed);
        logic [31:0]  beats [8];
        logic [31:0]  base;
        logic [255:0] line;
        int           crit;
        int           guard;

        base = addr & ~32'h1F;
        crit = int'((addr >> 2) % 8);
        for (int i = 0; i < 8; i++) begin
            beats[i] = directed ? (32'hA0 + 32'(i)) : $urandom;
            line[i*32 +: 32] = beats[i];
        end

        guard = 0;
        while (busy !== 1'b0 && guard < 50) begin
            tick();
            guard++;
        end
        check("idle_wait_bound", guard < 50, 1'b1);

        miss_req  = 1'b1;
        miss_addr = addr;
        exp_addr.push_back(base);
        exp_fwd.push_back(beats[crit]);
        exp_line.push_back(line);
        avm_waitrequest = 1'b1;
        tick();
        check("busy_after_accept", busy, 1'b1);
        miss_req  = spam;
        miss_addr = $urandom;

        repeat (nwait) tick();
        avm_waitrequest = 1'b0;
        tick();
        avm_waitrequest = 1'b1;

        for (int b = 0; b < 8; b++) begin
            if (b == abort_after) begin
                avm_readdatavalid = 1'b0;
                miss_req = 1'b0;
                if (crit >= abort_after) void'(exp_fwd.pop_back());
                void'(exp_line.pop_back());
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_read", avm_read, 1'b0);
                check("abort_addr", avm_address, 32'h0);
                check("abort_line", line_data, 256'h0);
                check("abort_fwd_data", fwd_data, 32'h0);
                check("abort_fwd_valid", fwd_valid, 1'b0);
                check("abort_line_valid", line_valid, 1'b0);
                repeat (3) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = $urandom;
                    tick();
                end
                avm_readdatavalid = 1'b0;
                check("stray_busy", busy, 1'b0);
                check("stray_line", line_data, 256'h0);
                return;
            end
            avm_readdatavalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
            avm_readdatavalid = 1'b1;
            avm_readdata      = beats[b];
            if (b == crit) exp_fwd_cyc.push_back(cyc + 1);
            if (b == 7)    exp_line_cyc.push_back(cyc + 1);
            tick();
        end
        avm_readdatavalid = 1'b0;
        // While spamming, keep the request up through the DONE cycle as well.
        if (spam) tick();
        miss_req = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        miss_req          = 1'b0;
        miss_addr         = '0;
        avm_waitrequest   = 1'b1;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_read", avm_read, 1'b0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_addr", avm_address, 32'h0);
        check("rst_line", line_data, 256'h0);
        check("rst_fwd_data", fwd_data, 32'h0);
        check("rst_burstcount", avm_burstcount, 4'd8);
        reset = 1'b0;
        tick();

        // Stray beats while idle must not start anything.
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        tick();
        avm_readdatavalid = 1'b0;
        check("idle_stray_busy", busy, 1'b0);

        do_fill(32'h1000_0014, 0, 0, 1'b0, -1, 1'b1);   // basic, crit 5
        do_fill(32'h2000_0040, 5, 0, 1'b0, -1, 1'b0);   // 5-cycle command stall, crit 0
        do_fill(32'h3000_001C, 1, 3, 1'b0, -1, 1'b0);   // gapped beats, crit 7
        do_fill(32'h4000_0108, 2, 2, 1'b1, -1, 1'b0);   // miss_req spammed during fill
        do_fill(32'h5000_0014, 0, 1, 1'b0, 4,  1'b1);   // reset after beat 3
        do_fill(32'h6000_0004, 0, 1, 1'b0, -1, 1'b0);   // recovery fill
        for (int k = 0; k < 10; k++) begin
            do_fill($urandom, $urandom_range(0, 3), 3, 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        repeat (5) tick();
        check("drain_addr", 32'(exp_addr.size()), 32'd0);
        check("drain_fwd", 32'(exp_fwd.size()), 32'd0);
        check("drain_line", 32'(exp_line.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
